// File: rtl/cpu_mode_ctrl_pkg.sv
// Shared front-panel / control-unit definitions: mode encodings and memory
// bus width defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IN    = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } cpu_state_e;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

endpackage

// File: rtl/cpu_mode_ctrl_sync_edge.sv
// Two-flop synchronizer for asynchronous board inputs, with an optional
// rising-edge pulse taken from a third flop (valid for exactly one cycle).
module sync_edge #(
  parameter int W       = 1,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign dout = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic [W-1:0] s3_q, s3_d;

      always_comb s3_d = s2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) s3_q <= '0;
        else     s3_q <= s3_d;
      end

      assign rise = s2_q & ~s3_q;
    end else begin : g_no_edge
      assign rise = '0;
    end
  endgenerate

endmodule

// File: rtl/cpu_mode_ctrl.sv
// Front-panel mode controller: follows the synchronized mode switches and
// either loads switch bytes into memory (IN) or steps a display address (CHECK).
module cpu_mode_ctrl
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode_sel,
  input  logic          step,
  input  logic [DW-1:0] sw_data,
  output logic [1:0]    cpustate,
  output logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_we,
  output logic          ld_sel,
  output logic          wrapped
);

  logic [1:0] mode_sync;
  logic       step_edge;

  sync_edge #(.W(2), .EDGE_EN(1'b0)) u_mode_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (mode_sel),
    .dout (mode_sync),
    .rise ()
  );

  sync_edge #(.W(1), .EDGE_EN(1'b1)) u_step_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (step),
    .dout (),
    .rise (step_edge)
  );

  cpu_state_e    state_q, state_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          ld_we_q, ld_we_d;
  logic          wrapped_q, wrapped_d;
  logic          mode_chg;

  assign mode_chg = (mode_sync != state_q);

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    ld_we_d   = 1'b0;
    wrapped_d = wrapped_q;

    // A pending strobe always finishes with its address bump, even when the
    // mode is changing; the entry action below may then override the address.
    if (ld_we_q) begin
      ld_addr_d = ld_addr_q + 1'b1;
      if (ld_addr_q == {AW{1'b1}}) wrapped_d = 1'b1;
    end

    if (mode_chg) begin
      state_d = cpu_state_e'(mode_sync);
      if (state_d == ST_IN || state_d == ST_CHECK) ld_addr_d = '0;
      if (state_d == ST_IN) wrapped_d = 1'b0;
    end else if (step_edge) begin
      case (state_q)
        ST_IN: begin
          if (!ld_we_q) begin
            ld_we_d   = 1'b1;
            ld_data_d = sw_data;
          end
        end
        ST_CHECK: ld_addr_d = ld_addr_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      ld_we_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      ld_we_q   <= ld_we_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign cpustate = state_q;
  assign ld_addr  = ld_addr_q;
  assign ld_data  = ld_data_q;
  assign ld_we    = ld_we_q;
  assign wrapped  = wrapped_q;
  assign ld_sel   = (state_q == ST_IN) || (state_q == ST_CHECK);

endmodule

// File: doc/cpu_mode_ctrl.md
Name: cpu_mode_ctrl

Overview:
- Front-panel mode controller that sits directly upstream of the instruction-cycle control unit.
- Produces the 2-bit cpustate the control unit consumes: IDLE, IN (program entry), CHECK (memory inspection) and RUN.
- In IN it writes switch bytes into main memory at an auto-incrementing address. In CHECK it steps a read address through memory for display.
- Switches and step button are asynchronous board inputs, synchronized here.

Parameters:
- AW, 8, memory address width
- DW, 8, memory data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- mode_sel  in  2  requested mode from board switches (00 IDLE, 01 IN, 10 CHECK, 11 RUN), asynchronous
- step  in  1  step push-button, asynchronous, already debounced on board
- sw_data  in  DW  data switches; only sampled in IN
- cpustate  out  2  current mode to control unit; RUN = 2'b11
- ld_addr  out  AW  memory address driven while in IN/CHECK
- ld_data  out  DW  write data for IN
- ld_we  out  1  one-cycle memory write strobe
- ld_sel  out  1  1 = memory address/data mux takes ld_*; 0 = CPU datapath owns memory
- wrapped  out  1  sticky: IN address wrapped past 2^AW-1

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- Reset values: cpustate=00, ld_addr=0, ld_data=0, ld_we=0, ld_sel=0, wrapped=0, all synchronizer flops 0.
- Reset asserted mid-write drops the strobe immediately; no partial state survives.
- Synchronization: mode_sel and step each pass through 2 flops.
- step rising edge = sync2 & ~sync3, where sync3 is a third flop; the edge is valid for exactly one cycle.
- Mode change:
  - mode_chg = (mode_sync2 != cpustate).
  - On mode_chg, cpustate <= mode_sync2 at the next edge.
  - Latency from the mode_sel change to the cpustate update is 3 clocks.
  - Any transition is legal, including RUN→IN.
- Entry actions, taken at the cycle cpustate changes:
  - entering IN or CHECK: ld_addr <= 0.
  - entering IN: wrapped <= 0.
  - any state: ld_we <= 0.
- ld_sel = (cpustate==IN || cpustate==CHECK). It is combinational from the registered state.
- IN:
  - On step_edge && !mode_chg, the next edge sets ld_we=1 and ld_data=sw_data. sw_data must be static at that edge; it is not synchronized.
  - On the edge ending the ld_we pulse: ld_we <= 0 and ld_addr <= ld_addr+1, mod 2^AW.
  - If ld_addr was 2^AW-1 at that increment, wrapped <= 1.
  - Step edges arriving while ld_we=1 cannot occur, since edges are ≥3 cycles apart; this needs no handling.
- CHECK:
  - On step_edge && !mode_chg: ld_addr <= ld_addr+1 (wraps, no flag). ld_we stays 0.
  - The displayed byte is the memory read data at ld_addr.
- IDLE/RUN: step ignored; ld_addr holds; ld_we=0.
- Simultaneous step edge and mode change: the mode change wins and the step is discarded.
- Leaving IN while ld_we=1: the strobe completes its single cycle and the address increment still happens, then the new mode's entry action applies.
- Priority order: rst > mode change > step.

Decomposition:
- Shared package cpu_pkg holds:
  - state constants ST_IDLE=2'b00, ST_IN=2'b01, ST_CHECK=2'b10, ST_RUN=2'b11. The control unit uses the same constants.
  - AW/DW defaults.
- One sub-module sync_edge: parameterised-width 2-flop synchronizer plus an optional rising-edge detect output.
- Two instances: one for mode_sel (width 2) and one for step (width 1).

Test Plan:
- Apply rst mid-operation with ld_addr=5 and ld_we=1 → all outputs read 0 asynchronously, before the next clk.
- mode_sel 00→01 at cycle 0 → cpustate=01 and ld_sel=1 at cycle 3, ld_addr=0.
- IN: sw_data=0xA5, pulse step (held 4 cycles) → exactly one ld_we cycle with ld_addr=0 and ld_data=0xA5, then ld_addr=1. Repeat with 0x3C → write at addr 1, then ld_addr=2.
- IN with ld_addr preset to 0xFF by 255 steps, one more step → write at 0xFF, ld_addr=0x00, wrapped=1. Re-enter IN → wrapped=0.
- CHECK: three steps → ld_addr 0→1→2→3 and ld_we never asserted. Switch to RUN (11) → cpustate=11, ld_sel=0, step ignored.
- Step edge and mode change synchronized into the same cycle (IN→CHECK) → no write, cpustate=10, ld_addr=0.
